// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the RV32I + Zicsr decode stage.
// Holds the major opcode constants, ALU and branch encodings, memory size and
// CSR operation codes, the registered decode bundle layout, and a helper that
// maps funct3 to an ALU operation.
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10   // result = operand b (LUI)
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6,
    BR_JUMP = 3'd7
  } branch_type_e;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  // CSR op codes equal funct3[1:0] of the CSR instructions.
  localparam logic [1:0] CSR_NONE = 2'd0;
  localparam logic [1:0] CSR_RW   = 2'd1;
  localparam logic [1:0] CSR_RS   = 2'd2;
  localparam logic [1:0] CSR_RC   = 2'd3;

  typedef struct packed {
    logic         valid;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic         uses_rs1;
    logic         uses_rs2;
    logic [31:0]  imm;
    alu_op_e      alu_op;
    logic         alu_sel_a;
    logic         alu_sel_b;
    branch_type_e branch_type;
    logic         jalr;
    logic         load;
    logic         store;
    logic         mem_signed;
    logic [1:0]   mem_size;
    logic         write_rd;
    logic [1:0]   csr_op;
    logic [11:0]  csr_addr;
    logic         ecall;
    logic         ebreak;
    logic         mret;
    logic         illegal;
  } dec_bundle_t;

  // funct3 -> ALU op; alt selects SUB/SRA (instr bit 30 where meaningful).
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// imm_gen: combinational immediate extraction for the decode stage.
// Ports: instr_i (raw instruction word) -> imm_o (32-bit immediate).
// Format is chosen from the major opcode; SYSTEM yields the zero-extended
// CSR uimm field; opcodes without an immediate yield 0.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  // Select the immediate format from the opcode.
  always_comb begin
    case (instr_i[6:0])
      OPC_LUI, OPC_AUIPC:
        imm_o = {instr_i[31:12], 12'd0};
      OPC_JAL:
        imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM:
        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      OPC_STORE:
        imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OPC_BRANCH:
        imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      OPC_SYSTEM:
        imm_o = {27'd0, instr_i[19:15]};
      default:
        imm_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// decode: single-stage registered RV32I + Zicsr instruction decoder.
// Inputs : clk, reset (async, active-high), valid_in, pc_in, next_pc_in,
//          instr_in, stall (hold outputs), flush (kill slot).
// Outputs: valid_out plus the decoded bundle (pc/next_pc copies, register
//          indices and use flags, immediate, ALU controls, branch/jump info,
//          memory controls, writeback enable, CSR op/address, system flags).
// Edge priority is flush > stall > load; every output comes from a register.
module decode
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] next_pc_in,
  input  logic [31:0] instr_in,
  input  logic        stall,
  input  logic        flush,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic [31:0] imm,
  output logic [3:0]  alu_op,
  output logic        alu_sel_a,
  output logic        alu_sel_b,
  output logic [2:0]  branch_type,
  output logic        jalr,
  output logic        load,
  output logic        store,
  output logic        mem_signed,
  output logic [1:0]  mem_size,
  output logic        write_rd,
  output logic [1:0]  csr_op,
  output logic [11:0] csr_addr,
  output logic        ecall,
  output logic        ebreak,
  output logic        mret,
  output logic        illegal
);

  logic [31:0] imm_s;
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic        wr_s;
  logic        ill_s;
  dec_bundle_t dec_s;
  dec_bundle_t bundle_d;
  dec_bundle_t bundle_q;

  assign opcode_s = instr_in[6:0];
  assign funct3_s = instr_in[14:12];
  assign funct7_s = instr_in[31:25];

  imm_gen u_imm_gen (
    .instr_i (instr_in),
    .imm_o   (imm_s)
  );

  // Decode instr_in into a candidate bundle.
  always_comb begin
    dec_s             = '0;
    dec_s.valid       = valid_in;
    dec_s.pc          = pc_in;
    dec_s.next_pc     = next_pc_in;
    dec_s.rs1         = instr_in[19:15];
    dec_s.rs2         = instr_in[24:20];
    dec_s.rd          = instr_in[11:7];
    dec_s.imm         = imm_s;
    dec_s.csr_addr    = instr_in[31:20];
    dec_s.alu_op      = ALU_ADD;
    dec_s.branch_type = BR_NONE;
    wr_s              = 1'b0;
    ill_s             = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        wr_s = 1'b1; dec_s.alu_sel_b = 1'b1; dec_s.alu_op = ALU_PASSB;
      end
      OPC_AUIPC: begin
        wr_s = 1'b1; dec_s.alu_sel_a = 1'b1; dec_s.alu_sel_b = 1'b1;
      end
      OPC_JAL: begin
        wr_s = 1'b1; dec_s.alu_sel_a = 1'b1; dec_s.alu_sel_b = 1'b1;
        dec_s.branch_type = BR_JUMP;
      end
      OPC_JALR: begin
        wr_s = 1'b1; dec_s.uses_rs1 = 1'b1; dec_s.alu_sel_b = 1'b1;
        dec_s.jalr = 1'b1; dec_s.branch_type = BR_JUMP;
        ill_s = (funct3_s != 3'b000);
      end
      OPC_BRANCH: begin
        dec_s.uses_rs1 = 1'b1; dec_s.uses_rs2 = 1'b1;
        case (funct3_s)
          3'b000:  dec_s.branch_type = BR_EQ;
          3'b001:  dec_s.branch_type = BR_NE;
          3'b100:  dec_s.branch_type = BR_LT;
          3'b101:  dec_s.branch_type = BR_GE;
          3'b110:  dec_s.branch_type = BR_LTU;
          3'b111:  dec_s.branch_type = BR_GEU;
          default: ill_s = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        wr_s = 1'b1; dec_s.uses_rs1 = 1'b1; dec_s.alu_sel_b = 1'b1;
        dec_s.load = 1'b1; dec_s.mem_size = funct3_s[1:0];
        dec_s.mem_signed = ~funct3_s[2];
        // valid: LB LH LW LBU LHU
        ill_s = (funct3_s[1:0] == 2'b11) || (funct3_s == 3'b110);
      end
      OPC_STORE: begin
        dec_s.uses_rs1 = 1'b1; dec_s.uses_rs2 = 1'b1; dec_s.alu_sel_b = 1'b1;
        dec_s.store = 1'b1; dec_s.mem_size = funct3_s[1:0];
        ill_s = funct3_s[2] || (funct3_s[1:0] == 2'b11);
      end
      OPC_OP_IMM: begin
        wr_s = 1'b1; dec_s.uses_rs1 = 1'b1; dec_s.alu_sel_b = 1'b1;
        // bit 30 only selects SRAI; for ADDI it is immediate data
        dec_s.alu_op = alu_from_f3(funct3_s, (funct3_s == 3'b101) && funct7_s[5]);
        if (funct3_s == 3'b001) begin
          ill_s = (funct7_s != 7'b0000000);
        end else if (funct3_s == 3'b101) begin
          ill_s = (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000);
        end else begin
          ill_s = 1'b0;
        end
      end
      OPC_OP: begin
        wr_s = 1'b1; dec_s.uses_rs1 = 1'b1; dec_s.uses_rs2 = 1'b1;
        dec_s.alu_op = alu_from_f3(funct3_s, funct7_s[5]);
        ill_s = !((funct7_s == 7'b0000000) ||
                  ((funct7_s == 7'b0100000) &&
                   ((funct3_s == 3'b000) || (funct3_s == 3'b101))));
      end
      OPC_MISC_MEM: begin
        // FENCE / FENCE.I retire as no-ops
        ill_s = (funct3_s[2:1] != 2'b00);
      end
      OPC_SYSTEM: begin
        if (funct3_s == 3'b000) begin
          if (instr_in[19:7] != 13'd0) begin
            ill_s = 1'b1;
          end else begin
            case (instr_in[31:20])
              12'h000: dec_s.ecall  = 1'b1;
              12'h001: dec_s.ebreak = 1'b1;
              12'h302: dec_s.mret   = 1'b1;
              default: ill_s = 1'b1;
            endcase
          end
        end else if (funct3_s == 3'b100) begin
          ill_s = 1'b1;
        end else begin
          wr_s = 1'b1;
          dec_s.csr_op   = funct3_s[1:0];
          dec_s.uses_rs1 = ~funct3_s[2];
        end
      end
      default: ill_s = 1'b1;
    endcase
    // Illegal instructions carry no side effects.
    if (ill_s) begin
      dec_s.load        = 1'b0;
      dec_s.store       = 1'b0;
      dec_s.mem_signed  = 1'b0;
      dec_s.mem_size    = MEM_B;
      dec_s.branch_type = BR_NONE;
      dec_s.jalr        = 1'b0;
      dec_s.csr_op      = CSR_NONE;
      dec_s.uses_rs1    = 1'b0;
      dec_s.uses_rs2    = 1'b0;
      dec_s.alu_sel_a   = 1'b0;
      dec_s.alu_sel_b   = 1'b0;
      dec_s.alu_op      = ALU_ADD;
      dec_s.ecall       = 1'b0;
      dec_s.ebreak      = 1'b0;
      dec_s.mret        = 1'b0;
      dec_s.write_rd    = 1'b0;
    end else begin
      dec_s.write_rd = wr_s && (instr_in[11:7] != 5'd0);
    end
    dec_s.illegal = ill_s;
  end

  // Next-state select: flush kills the slot, stall holds, otherwise load.
  always_comb begin
    if (flush) begin
      bundle_d       = bundle_q;
      bundle_d.valid = 1'b0;
    end else if (stall) begin
      bundle_d = bundle_q;
    end else begin
      bundle_d = dec_s;
    end
  end

  // Bundle register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bundle_q <= '0;
    end else begin
      bundle_q <= bundle_d;
    end
  end

  assign valid_out   = bundle_q.valid;
  assign pc_out      = bundle_q.pc;
  assign next_pc_out = bundle_q.next_pc;
  assign rs1_addr    = bundle_q.rs1;
  assign rs2_addr    = bundle_q.rs2;
  assign rd_addr     = bundle_q.rd;
  assign uses_rs1    = bundle_q.uses_rs1;
  assign uses_rs2    = bundle_q.uses_rs2;
  assign imm         = bundle_q.imm;
  assign alu_op      = bundle_q.alu_op;
  assign alu_sel_a   = bundle_q.alu_sel_a;
  assign alu_sel_b   = bundle_q.alu_sel_b;
  assign branch_type = bundle_q.branch_type;
  assign jalr        = bundle_q.jalr;
  assign load        = bundle_q.load;
  assign store       = bundle_q.store;
  assign mem_signed  = bundle_q.mem_signed;
  assign mem_size    = bundle_q.mem_size;
  assign write_rd    = bundle_q.write_rd;
  assign csr_op      = bundle_q.csr_op;
  assign csr_addr    = bundle_q.csr_addr;
  assign ecall       = bundle_q.ecall;
  assign ebreak      = bundle_q.ebreak;
  assign mret        = bundle_q.mret;
  assign illegal     = bundle_q.illegal;

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameters: none; RV32I base ISA plus Zicsr, fixed.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 valid_in  input  1  fetch holds a valid instruction this cycle.
REQ-005 pc_in  input  32  PC of the incoming instruction.
REQ-006 next_pc_in  input  32  pc_in+4 from fetch.
REQ-007 instr_in  input  32  raw instruction word.
REQ-008 stall  input  1  downstream hazard; hold all outputs.
REQ-009 flush  input  1  branch/trap redirect; kill the decode slot.
REQ-010 valid_out  output  1  decoded bundle valid.
REQ-011 pc_out, next_pc_out  output  32 each  registered copies of pc_in and next_pc_in.
REQ-012 rs1_addr, rs2_addr, rd_addr  output  5 each  register indices.
REQ-013 uses_rs1, uses_rs2  output  1 each  operand read required (hazard unit).
REQ-014 imm  output  32  sign-extended immediate.
REQ-015 alu_op  output  4  ALU function (package enum).
REQ-016 alu_sel_a, alu_sel_b  output  1 each  a: 0=rs1 1=pc; b: 0=rs2 1=imm.
REQ-017 branch_type  output  3  NONE/EQ/NE/LT/GE/LTU/GEU/JUMP.
REQ-018 jalr  output  1  jump target base is rs1, not pc.
REQ-019 load, store, mem_signed  output  1 each; mem_size  output  2  (0=B 1=H 2=W).
REQ-020 write_rd  output  1  writeback enable.
REQ-021 csr_op  output  2; csr_addr  output  12  Zicsr function and address.
REQ-022 ecall, ebreak, mret, illegal  output  1 each  exception/system flags.

Function
REQ-023 All outputs are registered; latency exactly one cycle from valid_in to valid_out.
REQ-024 Priority per edge: flush > stall > load.
REQ-025 flush=1: valid_out<=0 next cycle regardless of stall or valid_in; other outputs don't-care.
REQ-026 stall=1, flush=0: every output holds its value.
REQ-027 Neither: valid_out<=valid_in; all fields re-decoded from instr_in; with valid_in=0, fields may update but valid_out=0.
REQ-028 Immediates per I/S/B/U/J formats; bit 31 sign-extends; B/J bit 0 = 0; U = instr[31:12]<<12.
REQ-029 write_rd=0 when rd_addr=0, or for branch, store, ecall, ebreak, mret, fence, illegal.
REQ-030 uses_rs1=0 for LUI, AUIPC, JAL, and CSR*I; uses_rs2=1 only for R-type, branch, store.
REQ-031 AUIPC and JAL set alu_sel_a=1; JAL and JALR write next_pc via write_rd.
REQ-032 Any unknown opcode, funct3, or funct7 sets illegal=1 with valid_out=1; load, store, write_rd, and branch_type are forced inactive.
REQ-033 instr_in[1:0]!=2'b11 is illegal.
REQ-034 FENCE and FENCE.I decode as NOP: valid, no side effects.

Reset
REQ-035 Asserting reset at any time clears every output to 0 asynchronously, including mid-stall.
REQ-036 After reset deasserts, first valid_out=1 no earlier than one edge after valid_in=1.

Structure
REQ-037 Package decode_pkg holds opcode constants, alu_op enum, branch_type enum, mem_size and csr_op codes.
REQ-038 Sub-module imm_gen: combinational instr -> 32-bit immediate; decode instantiates it.

Verification
REQ-039 0x00500093 (addi x1,x0,5) -> valid_out=1, rd=1, rs1=0, imm=5, alu_op=ADD, alu_sel_b=1, write_rd=1.
REQ-040 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, branch_type=EQ, write_rd=0, uses_rs2=1.
REQ-041 0x0080A103 (lw x2,8(x1)) -> load=1, mem_size=2, mem_signed=1, imm=8, rs1=1, rd=2.
REQ-042 Stall 3 cycles with a new instr_in -> outputs unchanged; release -> new bundle next cycle; flush during stall -> valid_out=0 next edge.
REQ-043 0x00000000 -> illegal=1, valid_out=1, write_rd=0, load=0.
REQ-044 Reset asserted between edges while valid_out=1 -> valid_out=0 immediately, before the next clk edge.
